// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle unsigned MULTU/DIVU sequencer owning HI/LO
// Shift-add multiply and restoring divide, one bit per cycle, through an external ripple ALU.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mt_we,
  input  logic             mt_hi,
  input  logic [WIDTH-1:0] mt_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  output logic             alu_binv,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] operand;
  logic             accept;

  // hi[W-1] covers the remainder bit shifted out above the ALU width
  assign accept = alu_cout | hi[WIDTH-1];

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_comb begin
    alu_sel  = 2'b10;
    alu_a    = '0;
    alu_b    = '0;
    alu_binv = 1'b0;
    case (state)
      S_MUL: begin
        alu_a = hi;
        alu_b = operand;
      end
      S_DIV: begin
        alu_a    = {hi[WIDTH-2:0], lo[WIDTH-1]};
        alu_b    = operand;
        alu_binv = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      count   <= '0;
      operand <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            operand <= op_b;
            lo      <= op_a;
            hi      <= '0;
            count   <= '0;
            state   <= op_div ? S_DIV : S_MUL;
          end else if (mt_we) begin
            if (mt_hi) hi <= mt_data;
            else       lo <= mt_data;
          end
        end
        S_MUL: begin
          if (lo[0]) begin
            hi <= {alu_cout, alu_result[WIDTH-1:1]};
            lo <= {alu_result[0], lo[WIDTH-1:1]};
          end else begin
            hi <= {1'b0, hi[WIDTH-1:1]};
            lo <= {hi[0], lo[WIDTH-1:1]};
          end
          count <= count + CNT_W'(1);
          if (count == LAST) state <= S_DONE;
        end
        S_DIV: begin
          if (accept) begin
            hi <= alu_result;
            lo <= {lo[WIDTH-2:0], 1'b1};
          end else begin
            hi <= {hi[WIDTH-2:0], lo[WIDTH-1]};
            lo <= {lo[WIDTH-2:0], 1'b0};
          end
          count <= count + CNT_W'(1);
          if (count == LAST) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed scoreboard bench for muldiv_seq with a behavioural ripple ALU
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op_div = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        mt_we = 1'b0;
  logic        mt_hi = 1'b0;
  logic [31:0] mt_data = '0;
  logic [31:0] alu_a, alu_b, alu_result, hi, lo;
  logic [1:0]  alu_sel;
  logic        alu_binv, alu_cout, busy, done;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp;

  always #5 clk = ~clk;

  // ripple ALU in add/sub mode: binv inverts b and is the carry-in
  assign {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, (alu_binv ? ~alu_b : alu_b)} + {32'd0, alu_binv};

  muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_div(op_div),
    .op_a(op_a), .op_b(op_b), .mt_we(mt_we), .mt_hi(mt_hi), .mt_data(mt_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_binv(alu_binv),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit div, input logic [31:0] a, input logic [31:0] b);
    if (!div) return {32'd0, a} * {32'd0, b};
    if (b == 0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  task automatic start_op(input bit div, input logic [31:0] a, input logic [31:0] b, input bit with_mt);
    @(negedge clk);
    start = 1'b1; op_div = div; op_a = a; op_b = b;
    if (with_mt) begin
      mt_we = 1'b1; mt_hi = 1'b0; mt_data = 32'h0BAD_F00D;
    end
    exp_q.push_back(model(div, a, b));
    @(posedge clk);
    #1;
    start = 1'b0; mt_we = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    if (with_mt) check("start_beats_mt", {hi, lo}, {32'd0, a});
  endtask

  task automatic wait_done(input string tag, input bit disturb);
    int k;
    bit busy_ok;
    busy_ok = 1'b1;
    for (k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (disturb && k == 10) begin
        start = 1'b1; op_div = ~op_div; op_a = 32'h5555_0001; op_b = 32'h0000_0003;
        mt_we = 1'b1; mt_hi = 1'b1; mt_data = 32'hDEAD_BEEF;
      end
      if (disturb && k == 11) begin
        start = 1'b0; mt_we = 1'b0;
      end
      if (done) break;
      busy_ok &= busy;
    end
    check({tag, "_done_cycle"}, 64'(k), 64'd32);
    check({tag, "_busy_during"}, {63'd0, busy_ok}, 64'd1);
    if (exp_q.size() > 0) last_exp = exp_q.pop_front();
    check({tag, "_result"}, {hi, lo}, last_exp);
    @(negedge clk);
    check({tag, "_idle_after"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    check("idle_alu", {alu_a, alu_b}, 64'd0);
    check("idle_alu_ctl", {61'd0, alu_sel, alu_binv}, 64'd4);
    rst_n = 1'b1;

    start_op(1'b0, 32'd7, 32'd6, 1'b0);              wait_done("mul_7x6", 1'b0);
    check("mul_7x6_const", {hi, lo}, 64'h0000_0000_0000_002A);
    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); wait_done("mul_max", 1'b0);
    start_op(1'b1, 32'd100, 32'd7, 1'b0);            wait_done("div_100_7", 1'b0);
    start_op(1'b1, 32'h8000_0000, 32'd3, 1'b0);      wait_done("div_msb", 1'b0);
    check("div_msb_const", {hi, lo}, 64'h0000_0002_2AAA_AAAA);
    start_op(1'b1, 32'h1234_5678, 32'd0, 1'b0);      wait_done("div_zero", 1'b0);
    start_op(1'b0, 32'd12345, 32'd678, 1'b0);        wait_done("mul_disturbed", 1'b1);

    @(negedge clk);
    mt_we = 1'b1; mt_hi = 1'b1; mt_data = 32'hA5A5_A5A5;
    @(negedge clk);
    mt_we = 1'b0;
    check("mthi_write", {hi, lo}, {32'hA5A5_A5A5, last_exp[31:0]});
    mt_we = 1'b1; mt_hi = 1'b0; mt_data = 32'h1357_9BDF;
    @(negedge clk);
    mt_we = 1'b0;
    check("mtlo_write", {hi, lo}, 64'hA5A5_A5A5_1357_9BDF);

    start_op(1'b1, 32'hFEDC_BA98, 32'h0000_1234, 1'b1); wait_done("div_start_mt", 1'b0);

    for (int r = 0; r < 3; r++) begin
      start_op(r[0], $urandom, $urandom_range(1, 32'h00FF_FFFF), 1'b0);
      wait_done("random_op", 1'b0);
    end

    start_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midop_reset_hilo", {hi, lo}, 64'd0);
    check("midop_reset_busy_done", {62'd0, busy, done}, 64'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    start_op(1'b0, 32'd3, 32'd5, 1'b0);              wait_done("mul_after_reset", 1'b0);
    check("mul_3x5_const", {hi, lo}, 64'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
